// File: rtl/moldudp64_msg_track.sv
// MoldUDP64 message boundary tracker: strips the 20-byte header and follows the
// 2-byte big-endian length fields across 8-byte beats. Optional protocol error
// checking is built when MOLD_MSG_TRACK_ERR_EN is defined.
module moldudp64_msg_track #(
  parameter int P_L  = 8,
  parameter int ML_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [P_L*8-1:0]  data_i,
  input  logic              last_i,
  output logic              msg_len_v_o,
  output logic [ML_W-1:0]   msg_len_o,
  output logic [15:0]       msg_cnt_o,
  output logic              msg_start_o,
  output logic              msg_end_o,
  output logic              eos_o,
  output logic              err_o
);

  typedef enum logic [2:0] {HDR0, HDR1, HDR2, MSG, LEN_LO, DRAIN} state_t;

  state_t          state, state_n;
  logic [7:0]      hi_byte, hi_n;
  logic [ML_W-1:0] rem_n, len_l, len_sub;
  logic [15:0]     cnt_n, count;
  logic            start_n, end_n, eos_n, err_n, take_len;

  function automatic logic [7:0] byte_at(input logic [P_L*8-1:0] d, input logic [2:0] idx);
    return d[{idx, 3'b000} +: 8];
  endfunction

  assign count = {byte_at(data_i, 3'd2), byte_at(data_i, 3'd3)};

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_n  = state;
    rem_n    = msg_len_o;
    cnt_n    = msg_cnt_o;
    hi_n     = hi_byte;
    start_n  = 1'b0;
    end_n    = 1'b0;
    eos_n    = 1'b0;
    take_len = 1'b0;
    len_l    = '0;
    len_sub  = '0;

    case (state)
      HDR0: begin
        rem_n   = '0;
        cnt_n   = '0;
        state_n = HDR1;
      end
      HDR1: state_n = HDR2;
      HDR2: begin
        rem_n = '0;
        cnt_n = '0;
        if (count == 16'h0000) begin
          state_n = DRAIN;
        end else if (count == 16'hFFFF) begin
          eos_n   = 1'b1;
          state_n = DRAIN;
        end else begin
          take_len = 1'b1;
          len_l    = ML_W'({byte_at(data_i, 3'd4), byte_at(data_i, 3'd5)});
          len_sub  = ML_W'(2);
          cnt_n    = count - 16'd1;
          state_n  = MSG;
        end
      end
      MSG: begin
        if (msg_len_o >= ML_W'(P_L)) begin
          rem_n = msg_len_o - ML_W'(P_L);
          end_n = (rem_n == '0);
          if (rem_n == '0 && msg_cnt_o == '0) state_n = DRAIN;
        end else begin
          // rem == 0 means the message already closed on the previous beat.
          end_n = (msg_len_o != '0);
          if (msg_cnt_o == '0) begin
            rem_n   = '0;
            state_n = DRAIN;
          end else if (msg_len_o[2:0] != 3'd7) begin
            take_len = 1'b1;
            len_l    = ML_W'({byte_at(data_i, msg_len_o[2:0]),
                              byte_at(data_i, msg_len_o[2:0] + 3'd1)});
            len_sub  = ML_W'(6) - msg_len_o;
            cnt_n    = msg_cnt_o - 16'd1;
          end else begin
            hi_n    = byte_at(data_i, 3'd7);
            rem_n   = '0;
            state_n = LEN_LO;
          end
        end
      end
      LEN_LO: begin
        take_len = 1'b1;
        len_l    = ML_W'({hi_byte, byte_at(data_i, 3'd0)});
        len_sub  = ML_W'(7);
        cnt_n    = msg_cnt_o - 16'd1;
        state_n  = MSG;
      end
      default: ;
    endcase

    if (take_len) begin
      rem_n   = len_l - len_sub;
      start_n = 1'b1;
    end

`ifdef MOLD_MSG_TRACK_ERR_EN
    begin
      logic short_len, bad;
      short_len = take_len && (len_l < ML_W'(6));
      bad = short_len ||
            (last_i && ((state inside {HDR0, HDR1, LEN_LO}) || rem_n != '0 || cnt_n != '0));
      if (short_len) begin
        rem_n   = '0;
        cnt_n   = '0;
        start_n = 1'b0;
      end
      if (bad) state_n = DRAIN;
      err_n = ((state == HDR0) ? 1'b0 : err_o) | bad;
    end
`else
    err_n = 1'b0;
`endif

    if (last_i) state_n = HDR0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HDR0;
      hi_byte     <= '0;
      msg_len_o   <= '0;
      msg_cnt_o   <= '0;
      msg_len_v_o <= 1'b0;
      msg_start_o <= 1'b0;
      msg_end_o   <= 1'b0;
      eos_o       <= 1'b0;
      err_o       <= 1'b0;
    end else if (valid_i) begin
      // NOTE: registered state uses non-blocking assignment so all flops update together.
      state       <= state_n;
      hi_byte     <= hi_n;
      msg_len_o   <= rem_n;
      msg_cnt_o   <= cnt_n;
      msg_len_v_o <= 1'b1;
      msg_start_o <= start_n;
      msg_end_o   <= end_n;
      eos_o       <= eos_n;
      err_o       <= err_n;
    end else begin
      msg_len_v_o <= 1'b0;
      msg_start_o <= 1'b0;
      msg_end_o   <= 1'b0;
      eos_o       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moldudp64_msg_track.sv
// Scoreboard bench for moldudp64_msg_track: directed packets push expected
// per-beat results; a negedge monitor pops and compares on msg_len_v_o.
module tb_moldudp64_msg_track;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [63:0] data_i = '0;
  logic        last_i = 1'b0;
  logic        msg_len_v_o;
  logic [15:0] msg_len_o;
  logic [15:0] msg_cnt_o;
  logic        msg_start_o, msg_end_o, eos_o, err_o;

`ifdef MOLD_MSG_TRACK_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] cnt;
    logic        start;
    logic        fin;
    logic        eos;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  moldudp64_msg_track #(.P_L(8), .ML_W(16)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .last_i(last_i),
    .msg_len_v_o(msg_len_v_o), .msg_len_o(msg_len_o), .msg_cnt_o(msg_cnt_o),
    .msg_start_o(msg_start_o), .msg_end_o(msg_end_o), .eos_o(eos_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] pk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  function automatic exp_t ex(input logic [15:0] len, cnt, input logic st, fi, eo, er);
    return '{len: len, cnt: cnt, start: st, fin: fi, eos: eo, err: er};
  endfunction

  task automatic beat(input logic [63:0] d, input logic l, input exp_t e);
    @(posedge clk); #1;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
      last_i  = 1'b0;
    end
  endtask

  task automatic hdr();
    beat(pk(8'h53, 8'h45, 8'h53, 8'h53, 8'h49, 8'h4f, 8'h4e, 8'h31), 1'b0, ex(0, 0, 0, 0, 0, 0));
    beat(pk(8'h20, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0, ex(0, 0, 0, 0, 0, 0));
  endtask

  task automatic pkt_single();
    hdr();
    beat(pk(8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h06, 8'haa, 8'hbb), 1'b0, ex(4, 0, 1, 0, 0, 0));
    beat(pk(8'hcc, 8'hdd, 8'hee, 8'hff, 8'h12, 8'h34, 8'h56, 8'h78), 1'b1, ex(0, 0, 0, 1, 0, 0));
    idle(2);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (msg_len_v_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got output with empty scoreboard at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("msg_len", 32'(msg_len_o), 32'(e.len));
          check("msg_cnt", 32'(msg_cnt_o), 32'(e.cnt));
          check("msg_start", 32'(msg_start_o), 32'(e.start));
          check("msg_end", 32'(msg_end_o), 32'(e.fin));
          check("eos", 32'(eos_o), 32'(e.eos));
          check("err", 32'(err_o), 32'(e.err));
        end
      end else begin
        check("idle_pulses", 32'({msg_start_o, msg_end_o, eos_o}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          32'({msg_len_v_o, msg_len_o, msg_cnt_o[11:0], msg_start_o, msg_end_o, eos_o, err_o}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // One message, L=6
    pkt_single();

    // Two messages, second length field straddles beats 3/4
    hdr();
    beat(pk(8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h09, 8'h01, 8'h02), 1'b0, ex(7, 1, 1, 0, 0, 0));
    beat(pk(8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h00), 1'b0, ex(0, 1, 0, 1, 0, 0));
    beat(pk(8'h10, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27), 1'b0, ex(9, 0, 1, 0, 0, 0));
    beat(pk(8'h28, 8'h29, 8'h2a, 8'h2b, 8'h2c, 8'h2d, 8'h2e, 8'h2f), 1'b0, ex(1, 0, 0, 0, 0, 0));
    beat(pk(8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1, ex(0, 0, 0, 1, 0, 0));
    idle(2);

    // Heartbeat
    hdr();
    beat(pk(8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1, ex(0, 0, 0, 0, 0, 0));
    idle(2);

    // End of session: eos on beat 2 only
    hdr();
    beat(pk(8'h00, 8'h06, 8'hff, 8'hff, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0, ex(0, 0, 0, 0, 1, 0));
    beat(pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1, ex(0, 0, 0, 0, 0, 0));
    idle(2);

    // Three messages: mid-beat field, exact beat-aligned end, field at byte 0
    hdr();
    beat(pk(8'h00, 8'h07, 8'h00, 8'h03, 8'h00, 8'h06, 8'h41, 8'h42), 1'b0, ex(4, 2, 1, 0, 0, 0));
    beat(pk(8'h43, 8'h44, 8'h45, 8'h46, 8'h00, 8'h0a, 8'h51, 8'h52), 1'b0, ex(8, 1, 1, 1, 0, 0));
    beat(pk(8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59, 8'h5a), 1'b0, ex(0, 1, 0, 1, 0, 0));
    beat(pk(8'h00, 8'h08, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66), 1'b0, ex(2, 0, 1, 0, 0, 0));
    beat(pk(8'h67, 8'h68, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1, ex(0, 0, 0, 1, 0, 0));
    idle(2);

    // Truncated packet: L=100 but last on beat 4
    hdr();
    beat(pk(8'h00, 8'h08, 8'h00, 8'h01, 8'h00, 8'h64, 8'h00, 8'h00), 1'b0, ex(98, 0, 1, 0, 0, 0));
    beat(pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0, ex(90, 0, 0, 0, 0, 0));
    beat(pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1, ex(82, 0, 0, 0, 0, ERR_ON));
    idle(2);
    @(negedge clk);
    check("err_sticky", 32'(err_o), 32'(ERR_ON));
    pkt_single();

    // Reset during beat 3 of a count=5 packet
    hdr();
    beat(pk(8'h00, 8'h09, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h00), 1'b0, ex(4, 4, 1, 0, 0, 0));
    @(posedge clk); #1;
    data_i = pk(8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h06, 8'h05, 8'h06);
    last_i = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_len", 32'(msg_len_o), 32'd0);
    check("rst_mid_cnt", 32'(msg_cnt_o), 32'd0);
    check("rst_mid_flags",
          32'({msg_len_v_o, msg_start_o, msg_end_o, eos_o, err_o}), 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    rst     = 1'b0;
    pkt_single();

    idle(3);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
